// File: rtl/cdc_same_domain_rr_reg_arbiter.sv
// Round-robin arbiter feeding a one-entry output register (single clock, async active-low reset).
// Optional grant locking is built only when ARB_LOCK_EN is defined.
module cdc_same_domain_rr_reg_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      async_rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_lock,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [SRC_W-1:0]          out_src,
    input  logic                      out_ready
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [SRC_W-1:0]    ptr_q, ptr_d;
    logic [SRC_W-1:0]    out_src_q, out_src_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [SRC_W-1:0]    grant, ptr_nxt;
    logic [NUM_REQ-1:0]  eligible;
    logic                accept, any_vld, xfer;

`ifdef ARB_LOCK_EN
    logic                lock_vld_q, lock_vld_d;
    logic [SRC_W-1:0]    lock_own_q, lock_own_d;
    logic                owner_active;

    // An idle owner forfeits the lock, so RR resumes in the very same cycle.
    always_comb begin
        owner_active = lock_vld_q & req_valid[lock_own_q];
        eligible     = owner_active ? ((NUM_REQ'(1) << lock_own_q) & req_valid) : req_valid;
    end
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    assign eligible    = req_valid;
`endif

    // Rotating priority search starting at ptr_q.
    always_comb begin
        int idx;
        grant   = '0;
        any_vld = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!any_vld && eligible[idx]) begin
                any_vld = 1'b1;
                grant   = SRC_W'(idx);
            end
        end
    end

    assign accept  = (state_q == EMPTY) | out_ready;
    assign xfer    = accept & any_vld;
    assign ptr_nxt = (grant == SRC_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (any_vld) state_d = FULL;
            FULL:    if (out_ready) state_d = any_vld ? FULL : EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q == FULL);
        req_ready = xfer ? (NUM_REQ'(1) << grant) : '0;
        out_data  = out_data_q;
        out_src   = out_src_q;
    end

    always_comb begin
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        ptr_d      = ptr_q;
`ifdef ARB_LOCK_EN
        lock_vld_d = lock_vld_q;
        lock_own_d = lock_own_q;
        if (accept && lock_vld_q && !req_valid[lock_own_q]) lock_vld_d = 1'b0;
`endif
        if (xfer) begin
            out_data_d = req_data[int'(grant)*DATA_W +: DATA_W];
            out_src_d  = grant;
`ifdef ARB_LOCK_EN
            // A locking transfer keeps ptr parked so the owner stays first in line.
            if (req_lock[grant]) begin
                lock_vld_d = 1'b1;
                lock_own_d = grant;
            end else begin
                lock_vld_d = 1'b0;
                ptr_d      = ptr_nxt;
            end
`else
            ptr_d = ptr_nxt;
`endif
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            out_data_q <= '0;
            out_src_q  <= '0;
            ptr_q      <= '0;
`ifdef ARB_LOCK_EN
            lock_vld_q <= 1'b0;
            lock_own_q <= '0;
`endif
        end else begin
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
            ptr_q      <= ptr_d;
`ifdef ARB_LOCK_EN
            lock_vld_q <= lock_vld_d;
            lock_own_q <= lock_own_d;
`endif
        end
    end

endmodule
